// File: rtl/zx_nmi_pkg.sv
// zx_nmi_pkg: shared NMI controller types, default sizing and source indices.
package zx_nmi_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, HOLD, CLEARING} state_t;
    localparam int NSRC_DEF      = 4;
    localparam int PULSE_LEN_DEF = 16;
    localparam int CLR_RFSH_DEF  = 3;
    localparam int SRC_SPI = 0;
    localparam int SRC_BTN = 1;
    localparam int SRC_BRK = 2;
    localparam int SRC_EXT = 3;
endpackage

// File: rtl/znmi_multi_if.sv
// znmi_multi_if: Z80-side request/handshake bundle of the multi-source NMI controller.
interface znmi_multi_if #(parameter int NSRC = 4, parameter int SRCW = 3);
    logic            zpos, int_start, clr_nmi, rfsh_n;
    logic [NSRC-1:0] req, req_en, pend;
    logic            in_nmi, gen_nmi;
    logic [SRCW-1:0] nmi_src;
    modport master(output zpos, int_start, req, req_en, clr_nmi, rfsh_n,
                   input pend, in_nmi, gen_nmi, nmi_src);
    modport slave(input zpos, int_start, req, req_en, clr_nmi, rfsh_n,
                  output pend, in_nmi, gen_nmi, nmi_src);
endinterface

// File: rtl/nmi_prio_enc.sv
// nmi_prio_enc: lowest-index-wins priority encoder.
module nmi_prio_enc #(parameter int N = 4, parameter int W = 3) (
    input  logic [N-1:0] vec_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);
    assign any_o = |vec_i;
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) if (vec_i[i]) idx_o = W'(i);
    end
endmodule

// File: rtl/znmi_multi.sv
// znmi_multi: multi-source edge-triggered NMI controller with fixed-priority accept,
// programmable pulse length and refresh-counted handler exit.
module znmi_multi import zx_nmi_pkg::*; #(
    parameter int NSRC      = NSRC_DEF,
    parameter int PULSE_LEN = PULSE_LEN_DEF,
    parameter int CLR_RFSH  = CLR_RFSH_DEF,
    parameter int SRCW      = 3
) (
    input logic fclk,
    input logic rst_n,
    znmi_multi_if.slave bus
);
    state_t          state_q, state_d;
    logic [NSRC-1:0] req_r_q, pend_q, pend_d, fall, elig, clr_mask;
    logic [7:0]      pcnt_q, pcnt_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic            gen_q, gen_d, any, accept, rfsh;
    logic [SRCW-1:0] src_q, src_d, win;
    nmi_prio_enc #(.N(NSRC), .W(SRCW)) u_enc (.vec_i(elig), .any_o(any), .idx_o(win));
    assign fall     = req_r_q & ~bus.req;
    assign elig     = pend_q & bus.req_en;
    assign accept   = state_q == IDLE && bus.int_start && any;
    assign clr_mask = accept ? NSRC'(1) << win : '0;
    // a fresh fall on the accepted source re-arms it rather than being lost
    assign pend_d   = ((pend_q & ~clr_mask) | fall) & bus.req_en;
    assign rfsh     = bus.zpos && !bus.rfsh_n;
    assign bus.pend    = pend_q;
    assign bus.gen_nmi = gen_q;
    assign bus.in_nmi  = state_q != IDLE;
    assign bus.nmi_src = src_q;
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        rcnt_d  = rcnt_q;
        gen_d   = gen_q;
        src_d   = src_q;
        if (gen_q) begin
            gen_d  = pcnt_q != 0;
            pcnt_d = pcnt_q != 0 ? pcnt_q - 8'd1 : pcnt_q;
        end
        case (state_q)
            IDLE: if (accept) begin
                state_d = PULSE;
                src_d   = win;
                gen_d   = 1'b1;
                pcnt_d  = 8'(PULSE_LEN - 1);
            end
            PULSE: begin
                state_d = bus.clr_nmi ? CLEARING : pcnt_q == 0 ? HOLD : PULSE;
                rcnt_d  = bus.clr_nmi ? 4'(CLR_RFSH) : rcnt_q;
            end
            HOLD: begin
                state_d = bus.clr_nmi ? CLEARING : HOLD;
                rcnt_d  = bus.clr_nmi ? 4'(CLR_RFSH) : rcnt_q;
            end
            CLEARING: begin
                // the pulse may still be running here; exit only once it is done
                rcnt_d  = bus.clr_nmi ? 4'(CLR_RFSH) : rfsh && rcnt_q != 0 ? rcnt_q - 4'd1 : rcnt_q;
                state_d = !bus.clr_nmi && rcnt_q == 0 && !gen_q ? IDLE : CLEARING;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_r_q <= '0;
            pend_q  <= '0;
            pcnt_q  <= '0;
            rcnt_q  <= '0;
            gen_q   <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            req_r_q <= bus.req;
            pend_q  <= pend_d;
            pcnt_q  <= pcnt_d;
            rcnt_q  <= rcnt_d;
            gen_q   <= gen_d;
            src_q   <= src_d;
        end
    end
endmodule

// File: tb/tb_znmi_multi.sv
// tb_znmi_multi: directed self-checking bench for znmi_multi (NSRC=4, PULSE_LEN=16, CLR_RFSH=3).
module tb_znmi_multi;
    import zx_nmi_pkg::*;
    logic fclk = 1'b0, rst_n = 1'b0;
    int compared = 0, mismatched = 0, gcnt = 0;
    znmi_multi_if #(.NSRC(4), .SRCW(3)) bus ();
    znmi_multi #(.NSRC(4), .PULSE_LEN(16), .CLR_RFSH(3), .SRCW(3)) dut (
        .fclk(fclk), .rst_n(rst_n), .bus(bus));
    always #5 fclk = ~fclk;
    always @(negedge fclk) if (bus.gen_nmi === 1'b1) gcnt++;

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge fclk); #1; end
    endtask
    task automatic fall_src(input int i);
        bus.req[i] = 1'b0; tick(); bus.req[i] = 1'b1; tick();
    endtask
    task automatic int_pulse();
        bus.int_start = 1'b1; tick(); bus.int_start = 1'b0;
    endtask
    task automatic clr_pulse();
        bus.clr_nmi = 1'b1; tick(); bus.clr_nmi = 1'b0;
    endtask
    task automatic refresh(input int n);
        repeat (n) begin bus.zpos = 1'b1; bus.rfsh_n = 1'b0; tick(); bus.zpos = 1'b0; bus.rfsh_n = 1'b1; end
    endtask
    task automatic finish_nmi();
        clr_pulse(); refresh(3); tick();
    endtask

    task automatic test_reset();
        #3;
        compared++;
        if ({bus.gen_nmi, bus.in_nmi, bus.pend, bus.nmi_src} !== 9'b0) begin
            mismatched++; $display("FAIL reset_init: got %b required 0", {bus.gen_nmi, bus.in_nmi, bus.pend, bus.nmi_src});
        end
        @(posedge fclk); #1 rst_n = 1'b1; tick(2);
        fall_src(3); fall_src(2); int_pulse(); tick(3);
        compared++;
        if (bus.gen_nmi !== 1'b1 || bus.pend !== 4'b1000) begin
            mismatched++; $display("FAIL reset_pre: gen %b pend %b required 1 1000", bus.gen_nmi, bus.pend);
        end
        rst_n = 1'b0; #1;
        compared++;
        if ({bus.gen_nmi, bus.in_nmi, bus.pend} !== 6'b0) begin
            mismatched++; $display("FAIL reset_mid_pulse: got %b required 0", {bus.gen_nmi, bus.in_nmi, bus.pend});
        end
        @(posedge fclk); #1 rst_n = 1'b1; tick();
        compared++;
        if (bus.gen_nmi !== 1'b0 || bus.in_nmi !== 1'b0) begin
            mismatched++; $display("FAIL reset_after: gen %b in %b required 0 0", bus.gen_nmi, bus.in_nmi);
        end
        int_pulse();
        compared++;
        if (bus.gen_nmi !== 1'b0) begin
            mismatched++; $display("FAIL reset_no_pend: gen %b required 0", bus.gen_nmi);
        end
    endtask

    task automatic test_single();
        fall_src(SRC_BRK);
        compared++;
        if (bus.pend !== 4'b0100) begin
            mismatched++; $display("FAIL single_pend: got %b required 0100", bus.pend);
        end
        gcnt = 0; int_pulse();
        compared++;
        if ({bus.gen_nmi, bus.in_nmi, bus.nmi_src, bus.pend} !== {1'b1, 1'b1, 3'd2, 4'b0000}) begin
            mismatched++; $display("FAIL single_accept: gen %b in %b src %0d pend %b required 1 1 2 0000", bus.gen_nmi, bus.in_nmi, bus.nmi_src, bus.pend);
        end
        tick(20);
        compared++;
        if (gcnt !== 16 || bus.in_nmi !== 1'b1) begin
            mismatched++; $display("FAIL single_len: cycles %0d in %b required 16 1", gcnt, bus.in_nmi);
        end
        finish_nmi();
        compared++;
        if (bus.in_nmi !== 1'b0) begin
            mismatched++; $display("FAIL single_exit: in %b required 0", bus.in_nmi);
        end
    endtask

    task automatic test_priority();
        fall_src(3); fall_src(1);
        compared++;
        if (bus.pend !== 4'b1010) begin
            mismatched++; $display("FAIL prio_pend: got %b required 1010", bus.pend);
        end
        int_pulse();
        compared++;
        if (bus.nmi_src !== 3'd1 || bus.pend !== 4'b1000) begin
            mismatched++; $display("FAIL prio_first: src %0d pend %b required 1 1000", bus.nmi_src, bus.pend);
        end
        tick(16); clr_pulse(); refresh(3);
        compared++;
        if (bus.in_nmi !== 1'b1) begin
            mismatched++; $display("FAIL prio_hold_last: in %b required 1", bus.in_nmi);
        end
        tick();
        compared++;
        if (bus.in_nmi !== 1'b0) begin
            mismatched++; $display("FAIL prio_exit: in %b required 0", bus.in_nmi);
        end
        int_pulse();
        compared++;
        if (bus.nmi_src !== 3'd3 || bus.pend !== 4'b0000 || bus.gen_nmi !== 1'b1) begin
            mismatched++; $display("FAIL prio_second: src %0d pend %b gen %b required 3 0000 1", bus.nmi_src, bus.pend, bus.gen_nmi);
        end
        tick(16); finish_nmi();
    endtask

    task automatic test_disabled();
        bus.req_en = 4'b1110; fall_src(0);
        compared++;
        if (bus.pend !== 4'b0000) begin
            mismatched++; $display("FAIL dis_pend: got %b required 0000", bus.pend);
        end
        int_pulse();
        compared++;
        if (bus.gen_nmi !== 1'b0 || bus.in_nmi !== 1'b0) begin
            mismatched++; $display("FAIL dis_nmi: gen %b in %b required 0 0", bus.gen_nmi, bus.in_nmi);
        end
        bus.req_en = 4'b1111; fall_src(1); bus.req_en = 4'b1101; tick();
        compared++;
        if (bus.pend !== 4'b0000) begin
            mismatched++; $display("FAIL dis_mask_clear: got %b required 0000", bus.pend);
        end
        bus.req_en = 4'b1111;
    endtask

    task automatic test_clr_in_pulse();
        fall_src(2); gcnt = 0; int_pulse(); tick(4); clr_pulse(); refresh(3); tick(7);
        compared++;
        if (bus.gen_nmi !== 1'b1 || bus.in_nmi !== 1'b1) begin
            mismatched++; $display("FAIL cip_running: gen %b in %b required 1 1", bus.gen_nmi, bus.in_nmi);
        end
        tick();
        compared++;
        if (bus.gen_nmi !== 1'b0 || bus.in_nmi !== 1'b1 || gcnt !== 16) begin
            mismatched++; $display("FAIL cip_end: gen %b in %b cycles %0d required 0 1 16", bus.gen_nmi, bus.in_nmi, gcnt);
        end
        tick();
        compared++;
        if (bus.in_nmi !== 1'b0) begin
            mismatched++; $display("FAIL cip_exit: in %b required 0", bus.in_nmi);
        end
    endtask

    task automatic test_hold_reclear();
        fall_src(0); int_pulse(); tick(16); fall_src(2);
        compared++;
        if (bus.pend !== 4'b0100 || bus.gen_nmi !== 1'b0) begin
            mismatched++; $display("FAIL hold_pend: pend %b gen %b required 0100 0", bus.pend, bus.gen_nmi);
        end
        int_pulse(); tick();
        compared++;
        if (bus.gen_nmi !== 1'b0 || bus.pend !== 4'b0100 || bus.nmi_src !== 3'd0) begin
            mismatched++; $display("FAIL hold_no_accept: gen %b pend %b src %0d required 0 0100 0", bus.gen_nmi, bus.pend, bus.nmi_src);
        end
        clr_pulse(); refresh(1); clr_pulse(); refresh(2); tick();
        compared++;
        if (bus.in_nmi !== 1'b1) begin
            mismatched++; $display("FAIL hold_reload: in %b required 1", bus.in_nmi);
        end
        refresh(1); tick();
        compared++;
        if (bus.in_nmi !== 1'b0) begin
            mismatched++; $display("FAIL hold_exit: in %b required 0", bus.in_nmi);
        end
        int_pulse();
        compared++;
        if (bus.nmi_src !== 3'd2 || bus.pend !== 4'b0000 || bus.gen_nmi !== 1'b1) begin
            mismatched++; $display("FAIL hold_later_accept: src %0d pend %b gen %b required 2 0000 1", bus.nmi_src, bus.pend, bus.gen_nmi);
        end
        tick(16); finish_nmi();
    endtask

    task automatic test_back_to_back();
        fall_src(1);
        bus.req[1] = 1'b0; bus.int_start = 1'b1; tick(); bus.int_start = 1'b0; bus.req[1] = 1'b1;
        compared++;
        if (bus.nmi_src !== 3'd1 || bus.pend !== 4'b0010) begin
            mismatched++; $display("FAIL b2b_set_wins: src %0d pend %b required 1 0010", bus.nmi_src, bus.pend);
        end
        bus.req[3] = 1'b0; tick(); bus.req[3] = 1'b1; tick(15);
        finish_nmi();
        int_pulse();
        compared++;
        if (bus.nmi_src !== 3'd1 || bus.pend !== 4'b1000) begin
            mismatched++; $display("FAIL b2b_next: src %0d pend %b required 1 1000", bus.nmi_src, bus.pend);
        end
        tick(16); finish_nmi();
    endtask

    initial begin
        bus.req = 4'b1111; bus.req_en = 4'b1111;
        bus.zpos = 1'b0; bus.int_start = 1'b0; bus.clr_nmi = 1'b0; bus.rfsh_n = 1'b1;
        test_reset();
        tick(16); finish_nmi();
        test_single();
        test_priority();
        test_disabled();
        test_clr_in_pulse();
        test_hold_reclear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/znmi_multi.md
Name: znmi_multi

Overview:
Multi-source NMI controller. It is the parametrised successor of the single-channel z80 NMI generator and sits beside the Z80 core in the z80 subsystem. It collects NSRC edge-triggered NMI requests (slavespi, debug button, breakpoint unit, ...) and holds them pending per source. At INT start it arbitrates the pending sources by fixed priority and issues one NMI pulse of programmable length. While the handler runs it keeps in_nmi asserted, for ROM/RAM page mapping, until a clear write followed by CLR_RFSH refresh cycles.

Parameters:
NSRC, 4, number of request sources (1..8)
PULSE_LEN, 16, gen_nmi active length in fclk cycles (1..255)
CLR_RFSH, 3, Z80 refresh cycles (zpos && !rfsh_n) counted after clr_nmi before in_nmi drops (0..15)
SRCW, 3, width of nmi_src; must satisfy 2^SRCW >= NSRC

Ports:
fclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
zpos  in  1  Z80 clock positive-edge strobe
int_start  in  1  one-cycle strobe at start of INT
req  in  NSRC  request lines; falling edge = request
req_en  in  NSRC  per-source enable mask
clr_nmi  in  1  one-cycle pulse from zports on handler-exit write
rfsh_n  in  1  Z80 refresh, active low
pend  out  NSRC  pending flags
in_nmi  out  1  NMI handler active
gen_nmi  out  1  1 = drive NMI_N low
nmi_src  out  SRCW  index of the source accepted for the current/last NMI

Behaviour:
- One clock (fclk); reset asynchronous, active-low. All registers clear on reset: pend=0, in_nmi=0, gen_nmi=0, nmi_src=0, FSM=IDLE, counters=0, req_r=0.
- Edge detect: req_r <= req every cycle. fall[i] = req_r[i] & ~req[i]. pend[i] is set one cycle after fall[i] when req_en[i]=1. fall[i] with req_en[i]=0 is discarded.
- Clearing req_en[i] also clears pend[i] on the next edge.
- FSM states: IDLE, PULSE, HOLD, CLEARING.
- IDLE:
  - On int_start with (pend & req_en) != 0: winner = lowest set index.
  - On that edge: nmi_src <= winner, pend[winner] <= 0, in_nmi <= 1, pulse counter <= PULSE_LEN-1, gen_nmi <= 1, go to PULSE.
  - The other pending bits stay set (differs from the old block, which dropped all requests at INT).
- PULSE: counter decrements each fclk. When it reaches 0, gen_nmi <= 0 and go to HOLD. gen_nmi is high for exactly PULSE_LEN cycles.
- HOLD: in_nmi=1 and waits for clr_nmi.
- clr_nmi in PULSE or HOLD:
  - rfsh counter <= CLR_RFSH and go to CLEARING.
  - In PULSE, the pulse still completes; gen_nmi continues to its full length.
- CLEARING:
  - Counter decrements on each fclk with zpos && !rfsh_n && counter>0.
  - When counter==0 and the pulse is finished: in_nmi <= 0, go to IDLE.
  - A new clr_nmi reloads the counter.
  - CLR_RFSH=0: in_nmi drops on the cycle after clr_nmi (or at pulse end, if later).
- clr_nmi in IDLE is ignored.
- int_start outside IDLE does not accept. Pending sources wait for the first int_start after return to IDLE, so there is no back-to-back NMI inside one INT frame.
- Simultaneous events:
  - fall[winner] on the accept edge: set wins, and pend[winner] stays 1.
  - int_start and fall[i] on the same edge: fall[i] is not eligible for this arbitration, because arbitration uses the registered pend.
- nmi_src holds its value until the next accept.

Decomposition:
- Shared package zx_nmi_pkg holds:
  - the FSM state enum (IDLE/PULSE/HOLD/CLEARING)
  - the default NSRC, PULSE_LEN and CLR_RFSH constants
  - the source-index constants: SRC_SPI=0, SRC_BTN=1, SRC_BRK=2, SRC_EXT=3.
- One sub-module, nmi_prio_enc: a parametrised lowest-index priority encoder with outputs any and idx[SRCW-1:0].

Test Plan:
- Reset mid-PULSE (rst_n low for 1 cycle) -> gen_nmi, in_nmi and pend all 0 immediately; FSM IDLE.
- req[2] falls with req_en=4'b1111, then int_start -> gen_nmi high exactly 16 cycles; nmi_src=2; pend[2]=0; in_nmi=1.
- req[3] and req[1] both pending, then int_start -> nmi_src=1; pend=4'b1000. clr_nmi followed by 3 refresh strobes -> in_nmi=0. Next int_start -> nmi_src=3.
- req[0] falls with req_en[0]=0 -> pend stays 0; int_start gives no NMI.
- clr_nmi at pulse cycle 5 with CLR_RFSH=3 and 3 refresh strobes during the pulse -> gen_nmi still lasts 16 cycles; in_nmi drops the cycle after the pulse ends.
- In HOLD: clr_nmi, 1 refresh, clr_nmi again -> 3 further refreshes are needed before in_nmi=0. Also: int_start while in HOLD with pend=4'b0100 -> no new NMI.
